// File: rtl/afpm_pkg.sv
// Shared types and constants for the AFPM sequencing controller.
// Optional zero-operand bypass is enabled by defining AFPM_ZERO_BYPASS_EN.
package afpm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HI,
    ST_FIRE,
    ST_WAIT,
    ST_OUT_LO,
    ST_OUT_HI
  } afpm_state_e;

  localparam int FP16_SIGN    = 15;
  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_MAN_MSB = 9;
  localparam int FP16_MAN_LSB = 0;

  localparam int LAT_W = 4;

  // Signed zero: everything below the sign bit is clear.
  function automatic logic fp16_is_zero(input logic [15:0] x);
    return x[FP16_EXP_MSB:FP16_MAN_LSB] == '0;
  endfunction

endpackage

// File: rtl/afpm_lat_timer.sv
// Loadable down-counter that flags the last cycle of the multiplier latency.
module afpm_lat_timer
  import afpm_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal count is 1: the product is valid in the cycle the count reads 1.
  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/afpm_seq_ctrl.sv
// Byte-serial operand assembly, multiplier launch/wait and byte-serial result return.
// Define AFPM_ZERO_BYPASS_EN to short-circuit zero operands without firing the multiplier.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for low operand bytes
// LOAD_HI  | waiting for high operand bytes
// FIRE     | multiplier start pulse, latency timer loaded
// WAIT     | counting down multiplier latency
// OUT_LO   | presenting result low byte
// OUT_HI   | presenting result high byte
module afpm_seq_ctrl
  import afpm_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_byte,
  input  logic [7:0]  b_byte,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_go,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_hi,
  output logic        busy
);

  afpm_state_e state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic        mul_go_q, mul_go_d;
  logic        out_valid_q, out_valid_d;
  logic        out_hi_q, out_hi_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        tmr_load, tmr_dec, tmr_done;
  logic        bypass;

  afpm_lat_timer #(.W(LAT_W)) u_lat_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LAT_W'(MUL_LAT)),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    r_d         = r_q;
    mul_go_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_hi_d    = out_hi_q;
    out_byte_d  = out_byte_q;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    bypass      = 1'b0;
`ifdef AFPM_ZERO_BYPASS_EN
    bypass = fp16_is_zero(a_q) || fp16_is_zero(b_q);
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d[7:0] = a_byte;
          b_d[7:0] = b_byte;
          state_d  = ST_LOAD_HI;
        end
      end
      ST_LOAD_HI: begin
        if (in_valid) begin
          a_d[15:8] = a_byte;
          b_d[15:8] = b_byte;
          state_d   = ST_FIRE;
          // mul_go is registered, so the bypass decision is made on the assembled operands here.
`ifdef AFPM_ZERO_BYPASS_EN
          mul_go_d = !(fp16_is_zero(a_d) || fp16_is_zero(b_d));
`else
          mul_go_d = 1'b1;
`endif
        end
      end
      ST_FIRE: begin
        tmr_load = 1'b1;
        if (bypass || (MUL_LAT == 0)) begin
          r_d         = bypass ? {a_q[FP16_SIGN] ^ b_q[FP16_SIGN], 15'b0} : mul_p;
          state_d     = ST_OUT_LO;
          out_valid_d = 1'b1;
          out_hi_d    = 1'b0;
          out_byte_d  = r_d[7:0];
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_done) begin
          r_d         = mul_p;
          state_d     = ST_OUT_LO;
          out_valid_d = 1'b1;
          out_hi_d    = 1'b0;
          out_byte_d  = mul_p[7:0];
        end
      end
      ST_OUT_LO: begin
        if (out_ready) begin
          state_d    = ST_OUT_HI;
          out_hi_d   = 1'b1;
          out_byte_d = r_q[15:8];
        end
      end
      ST_OUT_HI: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_hi_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      mul_go_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_hi_q    <= 1'b0;
      out_byte_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      mul_go_q    <= mul_go_d;
      out_valid_q <= out_valid_d;
      out_hi_q    <= out_hi_d;
      out_byte_q  <= out_byte_d;
    end
  end

  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_go    = mul_go_q;
  assign out_valid = out_valid_q;
  assign out_hi    = out_hi_q;
  assign out_byte  = out_byte_q;
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD_HI);
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_afpm_seq_ctrl.sv
// Self-checking bench for afpm_seq_ctrl with an adder stub standing in for the multiplier.
module tb_afpm_seq_ctrl;

  localparam int TB_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mul_go, out_valid, out_ready, out_hi, busy;
  logic [7:0]  a_byte, b_byte, out_byte;
  logic [15:0] mul_a, mul_b, mul_p, p1, p2;

  logic        z_in_valid, z_in_ready, z_mul_go, z_out_valid, z_out_ready, z_out_hi, z_busy;
  logic [7:0]  z_a_byte, z_b_byte, z_out_byte;
  logic [15:0] z_mul_a, z_mul_b, z_mul_p;

  int vectors = 0;
  int miscompares = 0;
  int go_cnt = 0;

  always #5 clk = ~clk;

  afpm_seq_ctrl #(.MUL_LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_byte(a_byte), .b_byte(b_byte), .mul_a(mul_a), .mul_b(mul_b),
    .mul_go(mul_go), .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_hi(out_hi), .busy(busy)
  );

  afpm_seq_ctrl #(.MUL_LAT(0)) dut_lat0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .a_byte(z_a_byte), .b_byte(z_b_byte), .mul_a(z_mul_a), .mul_b(z_mul_b),
    .mul_go(z_mul_go), .mul_p(z_mul_p), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_byte(z_out_byte), .out_hi(z_out_hi), .busy(z_busy)
  );

  // Stub multiplier: sum of operands, delayed by TB_LAT (or combinational for the zero-latency instance).
  always_ff @(posedge clk) begin
    p1 <= mul_a + mul_b;
    p2 <= p1;
  end
  assign mul_p   = p2;
  assign z_mul_p = z_mul_a + z_mul_b;

  always @(negedge clk) if (mul_go === 1'b1) go_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

  // Reference: {fires multiplier, returned product}
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b);
`ifdef AFPM_ZERO_BYPASS_EN
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {1'b0, a[15] ^ b[15], 15'd0};
`endif
    return {1'b1, 16'(a + b)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int gap,
                        input int stall_lo, input int stall_hi, input bit noise);
    logic [16:0] r = ref_op(a, b);
    logic [15:0] ep = r[15:0];
    int exp_first = r[16] ? 3 + TB_LAT : 3;
    int go0 = go_cnt;
    int cyc;
    vectors++;
    if ({in_ready, busy} !== 2'b10) begin
      miscompares++; $display("FAIL op_idle: in_ready,busy=%b want 10", {in_ready, busy});
    end
    in_valid = 1'b1; a_byte = a[7:0]; b_byte = b[7:0];
    tick;
    in_valid = 1'b0; a_byte = $urandom; b_byte = $urandom;
    for (int g = 0; g < gap; g++) begin
      vectors++;
      if ({in_ready, busy} !== 2'b11) begin
        miscompares++; $display("FAIL load_hi_gap: in_ready,busy=%b want 11", {in_ready, busy});
      end
      tick;
    end
    in_valid = 1'b1; a_byte = a[15:8]; b_byte = b[15:8];
    tick;
    in_valid = 1'b0;
    cyc = 2;
    vectors++;
    if (mul_go !== r[16]) begin
      miscompares++; $display("FAIL mul_go_cycle2: got %b want %b", mul_go, r[16]);
    end
    while (out_valid !== 1'b1 && cyc < 60) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++; $display("FAIL in_ready_busy: got %b want 0 (cycle %0d)", in_ready, cyc);
      end
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1)); a_byte = $urandom; b_byte = $urandom;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (cyc != exp_first) begin
      miscompares++; $display("FAIL first_out_valid: cycle %0d want %0d", cyc, exp_first);
    end
    vectors++;
    if ({mul_a, mul_b} !== {a, b}) begin
      miscompares++; $display("FAIL operands: mul_a=%h mul_b=%h want %h %h", mul_a, mul_b, a, b);
    end
    vectors++;
    if (go_cnt - go0 != int'(r[16])) begin
      miscompares++; $display("FAIL mul_go_count: got %0d want %0d", go_cnt - go0, r[16]);
    end
    out_ready = 1'b0;
    for (int s = 0; s <= stall_lo; s++) begin
      if (s == stall_lo) out_ready = 1'b1;
      vectors++;
      if ({out_valid, out_hi, out_byte} !== {1'b1, 1'b0, ep[7:0]}) begin
        miscompares++;
        $display("FAIL out_lo: v,hi,byte=%b,%b,%h want 1,0,%h", out_valid, out_hi, out_byte, ep[7:0]);
      end
      tick;
    end
    out_ready = 1'b0;
    for (int s = 0; s <= stall_hi; s++) begin
      if (s == stall_hi) out_ready = 1'b1;
      vectors++;
      if ({out_valid, out_hi, out_byte} !== {1'b1, 1'b1, ep[15:8]}) begin
        miscompares++;
        $display("FAIL out_hi: v,hi,byte=%b,%b,%h want 1,1,%h", out_valid, out_hi, out_byte, ep[15:8]);
      end
      tick;
    end
    out_ready = 1'b0;
    vectors++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      miscompares++; $display("FAIL back_idle: busy,out_valid,in_ready=%b want 001", {busy, out_valid, in_ready});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_byte = 8'h00; b_byte = 8'h00;
    z_in_valid = 1'b0; z_out_ready = 1'b0; z_a_byte = 8'h00; z_b_byte = 8'h00;
    tick; tick;
    rst = 1'b0;
    vectors++;
    if ({mul_a, mul_b, out_byte, mul_go, out_valid, out_hi, busy, in_ready} !== {40'd0, 5'b00001}) begin
      miscompares++;
      $display("FAIL reset_values: a=%h b=%h byte=%h go=%b v=%b hi=%b busy=%b rdy=%b",
               mul_a, mul_b, out_byte, mul_go, out_valid, out_hi, busy, in_ready);
    end
    vectors++;
    if ({z_mul_a, z_out_valid, z_busy, z_in_ready} !== {16'd0, 3'b001}) begin
      miscompares++; $display("FAIL reset_values_lat0: a=%h v=%b busy=%b rdy=%b", z_mul_a, z_out_valid, z_busy, z_in_ready);
    end
  endtask

  task automatic test_basic;
    run_op(16'h43BC, 16'h4190, 0, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_op(16'h43BC, 16'h4190, 0, 4, 2, 1'b0);
  endtask

  task automatic test_input_gaps;
    run_op(16'h43BC, 16'h4190, 3, 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_wait;
    in_valid = 1'b1; a_byte = 8'h11; b_byte = 8'h22;
    tick;
    a_byte = 8'h33; b_byte = 8'h44;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++;
    if ({mul_a, mul_b, out_byte, mul_go, out_valid, out_hi, busy, in_ready} !== {40'd0, 5'b00001}) begin
      miscompares++;
      $display("FAIL reset_mid_wait: a=%h b=%h byte=%h go=%b v=%b hi=%b busy=%b rdy=%b",
               mul_a, mul_b, out_byte, mul_go, out_valid, out_hi, busy, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({out_valid, busy} !== 2'b00) begin
        miscompares++; $display("FAIL late_mul_p_ignored: out_valid,busy=%b want 00", {out_valid, busy});
      end
      tick;
    end
    run_op(16'h3C00, 16'h3C00, 0, 0, 0, 1'b0);
  endtask

  task automatic test_lat0;
    z_in_valid = 1'b1; z_a_byte = 8'h01; z_b_byte = 8'h02;
    tick;
    z_a_byte = 8'h00; z_b_byte = 8'h00;
    tick;
    z_in_valid = 1'b0;
    vectors++;
    if ({z_mul_go, z_out_valid} !== 2'b10) begin
      miscompares++; $display("FAIL lat0_cycle2: go,v=%b want 10", {z_mul_go, z_out_valid});
    end
    tick;
    z_out_ready = 1'b1;
    vectors++;
    if ({z_mul_go, z_out_valid, z_out_hi, z_out_byte} !== {3'b010, 8'h03}) begin
      miscompares++; $display("FAIL lat0_cycle3: go,v,hi,byte=%b,%b,%b,%h want 0,1,0,03", z_mul_go, z_out_valid, z_out_hi, z_out_byte);
    end
    tick;
    vectors++;
    if ({z_out_valid, z_out_hi, z_out_byte} !== {2'b11, 8'h00}) begin
      miscompares++; $display("FAIL lat0_hi: v,hi,byte=%b,%b,%h want 1,1,00", z_out_valid, z_out_hi, z_out_byte);
    end
    tick;
    z_out_ready = 1'b0;
    vectors++;
    if ({z_busy, z_out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL lat0_idle: busy,v=%b want 00", {z_busy, z_out_valid});
    end
  endtask

  task automatic test_zero_operand;
    run_op(16'h8000, 16'h4190, 0, 0, 0, 1'b0);
    run_op(16'h3C00, 16'h0000, 1, 1, 1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a = 16'($urandom);
      logic [15:0] b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = a & 16'h8000;
        1: b = b & 16'h8000;
        default: ;
      endcase
      run_op(a, b, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) run_op(16'h1000 * 16'(i + 1), 16'h0123, 0, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_input_gaps;
    test_reset_mid_wait;
    test_lat0;
    test_zero_operand;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
